// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared state type, latency constants and latency helper for the
// sdp_ram_param simple dual-port RAM slice.
package sdp_ram_pkg;

    typedef enum logic {
        INIT,
        RUN
    } sdp_state_e;

    // Input register stage plus registered array read.
    localparam int SDP_BASE_LAT = 2;

    function automatic int sdp_lat_f(input int out_reg);
        return SDP_BASE_LAT + ((out_reg != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: bare storage array with a byte-enable merged registered write and a
// registered read; no reset and no control, so reads of a written address are read-first.
module sdp_ram_core
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int NBYTES = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Callers guarantee both addresses are in range whenever the matching enable is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sdp_ram_param.sv
// sdp_ram_param: single-clock simple dual-port RAM with byte enables, a zeroing sweep after
// reset and a rd_valid strobe. Define SDP_RAM_BYPASS_EN for same-address write-to-read forwarding.
module sdp_ram_param
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BYTE_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int OUT_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     ready
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int LAT    = sdp_lat_f(OUT_REG);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    sdp_state_e state, state_nxt;
    logic [ADDR_W:0] sweep_cnt, sweep_cnt_nxt;

    logic wr_in_range, rd_in_range;

    logic              s1_wr_en;
    logic [ADDR_W-1:0] s1_wr_addr;
    logic [DATA_W-1:0] s1_wr_data;
    logic [NBYTES-1:0] s1_wr_be;
    logic [ADDR_W-1:0] s1_rd_addr;
    logic              s1_rd_oor;
    logic              s2_oor;
    logic [LAT-1:0]    rd_vld_pipe;

    logic [DATA_W-1:0] core_rd_data;
    logic [DATA_W-1:0] rd_word;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign ready       = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    // The counter overshoots to DEPTH so the last sweep write leaves the input stage before RUN.
    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        case (state)
            INIT: begin
                if (sweep_cnt == DEPTH_C) begin
                    state_nxt = RUN;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + 1'b1;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_wr_en   <= 1'b0;
            s1_wr_addr <= '0;
            s1_wr_data <= '0;
            s1_wr_be   <= '0;
        end else if (state == INIT) begin
            s1_wr_en   <= (sweep_cnt != DEPTH_C);
            s1_wr_addr <= sweep_cnt[ADDR_W-1:0];
            s1_wr_data <= '0;
            s1_wr_be   <= '1;
        end else begin
            s1_wr_en   <= wr_en && wr_in_range;
            s1_wr_addr <= wr_addr;
            s1_wr_data <= wr_data;
            s1_wr_be   <= wr_be;
        end
    end

    // Bit 0 of the valid pipe doubles as the registered read request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_pipe <= '0;
            s1_rd_addr  <= '0;
            s1_rd_oor   <= 1'b0;
            s2_oor      <= 1'b0;
        end else begin
            rd_vld_pipe <= {rd_vld_pipe[LAT-2:0], rd_en && ready};
            s1_rd_addr  <= rd_addr;
            s1_rd_oor   <= !rd_in_range;
            s2_oor      <= s1_rd_oor;
        end
    end

    sdp_ram_core #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .wr_en   (s1_wr_en),
        .wr_addr (s1_wr_addr),
        .wr_data (s1_wr_data),
        .wr_be   (s1_wr_be),
        .rd_en   (rd_vld_pipe[0] && !s1_rd_oor),
        .rd_addr (s1_rd_addr),
        .rd_data (core_rd_data)
    );

`ifdef SDP_RAM_BYPASS_EN
    logic              s2_fwd;
    logic [DATA_W-1:0] s2_fwd_data;
    logic [NBYTES-1:0] s2_fwd_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_fwd      <= 1'b0;
            s2_fwd_data <= '0;
            s2_fwd_be   <= '0;
        end else begin
            s2_fwd      <= s1_wr_en && rd_vld_pipe[0] && !s1_rd_oor && (s1_wr_addr == s1_rd_addr);
            s2_fwd_data <= s1_wr_data;
            s2_fwd_be   <= s1_wr_be;
        end
    end
`endif

    // Idle and out-of-range responses read as zero, which also gives rd_data its reset value.
    always_comb begin
        rd_word = core_rd_data;
`ifdef SDP_RAM_BYPASS_EN
        for (int i = 0; i < NBYTES; i++) begin
            if (s2_fwd && s2_fwd_be[i]) begin
                rd_word[i*BYTE_W +: BYTE_W] = s2_fwd_data[i*BYTE_W +: BYTE_W];
            end
        end
`endif
        if (!rd_vld_pipe[1] || s2_oor) begin
            rd_word = '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= rd_word;
                end
            end
        end else begin : g_out_comb
            assign rd_data = rd_word;
        end
    endgenerate

    assign rd_valid = rd_vld_pipe[LAT-1];

endmodule

// File: tb/tb_sdp_ram_param.sv
// tb_sdp_ram_param: drives three sdp_ram_param builds (default, DEPTH=20, OUT_REG=1) from shared
// inputs and compares every cycle against a word-level memory model with a response queue.
module tb_sdp_ram_param;

    localparam int NI  = 3;
    localparam int BIG = 1 << 30;

`ifdef SDP_RAM_BYPASS_EN
    localparam logic [31:0] COLL7 = 32'hA5A5A5A5;
    localparam logic [31:0] COLL3 = 32'h0000BEEF;
`else
    localparam logic [31:0] COLL7 = 32'h12345678;
    localparam logic [31:0] COLL3 = 32'h00000000;
`endif

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wbe;
        logic        re;
        logic [4:0]  ra;
        logic [31:0] exp_d;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data_w [NI];
    logic        rd_valid_w [NI];
    logic        ready_w [NI];

    exp_t        exp_q [$];
    logic [31:0] mem_m [NI][32];
    int          rdy_cyc [NI];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    vec_t        tbl [12];

    always #5 clk = ~clk;

    sdp_ram_param u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .ready(ready_w[0])
    );

    sdp_ram_param #(.DEPTH(20)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .ready(ready_w[1])
    );

    sdp_ram_param #(.OUT_REG(1)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_w[2]), .rd_valid(rd_valid_w[2]), .ready(ready_w[2])
    );

    function automatic int dep_of(input int k);
        return (k == 1) ? 20 : 32;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = nw[i*8 +: 8];
        end
        return res;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_output();
        for (int k = 0; k < NI; k++) begin
            logic        ev;
            logic [31:0] ed;
            ev = 1'b0;
            ed = '0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].inst == k && exp_q[i].due == cyc) begin
                    ev = 1'b1;
                    ed = exp_q[i].data;
                    exp_q.delete(i);
                    break;
                end
            end
            compare($sformatf("rd_valid[%0d]", k), 32'(rd_valid_w[k]), 32'(ev));
            if (ev) compare($sformatf("rd_data[%0d]", k), rd_data_w[k], ed);
            compare($sformatf("ready[%0d]", k), 32'(ready_w[k]), (cyc >= rdy_cyc[k]) ? 32'd1 : 32'd0);
            if (rst) compare($sformatf("reset_rd_data[%0d]", k), rd_data_w[k], 32'h0);
        end
    endtask

    // One cycle: drive inputs, update the model for accepted requests, then check after the edge.
    task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                  input logic [3:0] wbe, input logic re, input logic [4:0] ra,
                                  input logic use_exp, input logic [31:0] exp_d);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = wbe;
        rd_en   = re;
        rd_addr = ra;
        for (int k = 0; k < NI; k++) begin
            logic [31:0] res;
            if (!rst && cyc >= rdy_cyc[k]) begin
                if (re) begin
                    res = (int'(ra) < dep_of(k)) ? mem_m[k][ra] : 32'h0;
`ifdef SDP_RAM_BYPASS_EN
                    if (we && wa == ra && int'(ra) < dep_of(k)) res = merge(res, wd, wbe);
`endif
                    if (use_exp && k == 0) res = exp_d;
                    exp_q.push_back('{k, cyc + lat_of(k), res});
                end
                if (we && int'(wa) < dep_of(k)) mem_m[k][wa] = merge(mem_m[k][wa], wd, wbe);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check_output();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input int hold);
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NI; k++) rdy_cyc[k] = BIG;
        repeat (hold) begin
            @(posedge clk);
            cyc++;
            #1;
            check_output();
            @(negedge clk);
        end
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < dep_of(k); a++) mem_m[k][a] = 32'h0;
            rdy_cyc[k] = cyc + dep_of(k) + 1;
        end
    endtask

    task automatic measure_ready(input string tag);
        int n;
        int n1;
        n  = 0;
        n1 = -1;
        while (ready_w[0] !== 1'b1 && n < 100) begin
            idle(1);
            n++;
            if (n1 < 0 && ready_w[1] === 1'b1) n1 = n;
        end
        compare({tag, "_latency_d32"}, 32'(n), 32'd33);
        compare({tag, "_latency_d20"}, 32'(n1), 32'd21);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first;
        int cnt;
        int last;
        int c0;
        int vcount;
        logic [4:0] ra;
        logic [4:0] wa;

        tbl[0]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b1, 5'd0,  32'h00000000};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b1, 5'd15, 32'h00000000};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b1, 5'd31, 32'h00000000};
        tbl[3]  = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF,    1'b0, 5'd0,  32'h0};
        tbl[4]  = '{1'b1, 5'd5, 32'h11223344, 4'b0101, 1'b0, 5'd0,  32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b1, 5'd5,  32'hDE22BE44};
        tbl[6]  = '{1'b1, 5'd7, 32'h12345678, 4'hF,    1'b0, 5'd0,  32'h0};
        tbl[7]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 4'hF,    1'b1, 5'd7,  COLL7};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b1, 5'd7,  32'hA5A5A5A5};
        tbl[9]  = '{1'b1, 5'd3, 32'h0000BEEF, 4'b0011, 1'b1, 5'd3,  COLL3};
        tbl[10] = '{1'b1, 5'd3, 32'hFFFF0000, 4'b0000, 1'b1, 5'd3,  32'h0000BEEF};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b1, 5'd3,  32'h0000BEEF};

        @(negedge clk);
        do_reset(2);
        measure_ready("init");

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wbe, tbl[i].re, tbl[i].ra,
                           tbl[i].re, tbl[i].exp_d);
        end
        idle(4);

        // Out-of-range write and read on the 20-deep build; address 25 is real storage at depth 32.
        apply_stimulus(1'b1, 5'd19, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 5'd25, 32'h55AA55AA, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd25, 1'b0, 32'h0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd19, 1'b0, 32'h0);
        compare("d20_oor_valid", 32'(rd_valid_w[1]), 32'd1);
        compare("d20_oor_data", rd_data_w[1], 32'h0);
        compare("d32_addr25", rd_data_w[0], 32'h55AA55AA);
        idle(1);
        compare("d20_addr19", rd_data_w[1], 32'hCAFEF00D);
        idle(2);

        // Back-to-back reads through the output-registered build.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0);
        end
        first = -1;
        cnt   = 0;
        last  = -1;
        c0    = cyc;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), 1'b0, 32'h0);
            else idle(1);
            if (rd_valid_w[2]) begin
                if (first < 0) first = cyc;
                cnt++;
                last = cyc;
            end
        end
        compare("oreg_first_valid", 32'(first), 32'(c0 + 3));
        compare("oreg_valid_count", 32'(cnt), 32'd8);
        compare("oreg_last_valid", 32'(last), 32'(c0 + 10));

        for (int i = 0; i < 600; i++) begin
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            apply_stimulus(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), ra, 1'b0, 32'h0);
        end
        idle(4);

        // Reset with reads in flight, then again partway through the sweep.
        apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 1'b0, 32'h0);
        do_reset(1);
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            for (int k = 0; k < NI; k++) if (rd_valid_w[k]) vcount++;
        end
        compare("flush_no_valid", 32'(vcount), 32'd0);
        idle(5);
        do_reset(2);
        measure_ready("resweep");

        apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0);
        apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 1'b0, 32'h0);
        compare("resweep_addr5_zero", rd_data_w[0], 32'h0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
